maj_net_scanner: RTL
====================

Name: maj_net_scanner

Overview:
- Sequencer for a programmable network of 3-input majority gates over 7 inputs x0..x6.
- Time-shares one MAJ3 evaluator: evaluates one gate per cycle, in gate order, for each of the 128 input patterns.
- Assembles the 128-bit truth table of the network output, so the function signature is produced in hardware.
- Configured through a simple register-write port; started and completed with a start/done handshake.

Parameters:
- NUM_GATES, 6: gates in the network, legal range 1..8. The output is gate NUM_GATES-1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- cfg_we  input  1  config write strobe
- cfg_gate  input  3  gate index written
- cfg_sel_a  input  4  operand A source
- cfg_sel_b  input  4  operand B source
- cfg_sel_c  input  4  operand C source
- cfg_err  output  1  one-cycle pulse: write rejected
- start  input  1  begin scan (level sampled)
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse: scan complete
- out_valid  output  1  per-pattern result strobe
- out_idx  output  7  pattern index of out_bit
- out_bit  output  1  network output for pattern out_idx
- tt  output  128  truth table, tt[p] = output for pattern p

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: every output is 0, all gate config is 0, state is IDLE. Reset mid-scan aborts with no done pulse.
- Source codes:
  - 0: constant 0
  - 1..7: x0..x6
  - 8+j: w[j] if j < NUM_GATES, otherwise constant 0
- Pattern mapping: for pattern p, x_k = p[k].
- Gate function: w[g] = MAJ(a, b, c) = ab | ac | bc.
- Config writes:
  - Accepted only in IDLE.
  - A write with cfg_gate >= NUM_GATES is dropped and pulses cfg_err.
  - Any write while busy is dropped and pulses cfg_err the next cycle.
- States: IDLE, EVAL, DONE.
- IDLE:
  - start=1 moves to EVAL with p=0, g=0.
  - All w registers are cleared and tt is cleared.
  - busy rises the next cycle.
- EVAL, one gate per cycle:
  - Compute gate g from the current operands and register the result into w[g].
  - An operand selecting w[j] with j >= g reads the value cleared at pattern start, i.e. 0. Gates never see results from earlier patterns.
  - On g = NUM_GATES-1: write tt[p], and pulse out_valid with out_idx=p and out_bit equal to the result, registered and visible the next cycle.
  - Then clear w, set g=0, p=p+1.
  - If p=127, go to DONE instead.
- DONE: pulse done for one cycle, drop busy in the same cycle, return to IDLE.
- Latency: start sampled at edge 0 gives done high 128*NUM_GATES+1 cycles later (769 for NUM_GATES=6). tt is stable and held from done until the next accepted start.
- start while busy or in DONE is ignored.
- cfg_we and start in the same IDLE cycle: the config write takes effect and the scan starts, using the new config.
- p wraps only at scan end. There is no free-running wrap.

Optional Feature:
- Macro: MAJ_INV_EN.
- Defined:
  - Adds input port cfg_inv[2:0], one bit per operand A/B/C.
  - Stores a per-gate complement flag for each operand; the flag inverts the selected operand before MAJ.
  - Source 0 with its inv bit set gives constant 1, so AND/OR forms are reachable.
  - Reset value of the flags is 0.
- Undefined: no cfg_inv port, no storage, operands are never inverted.

Test Plan:
- Reset, then start with default config -> done at cycle 769, tt=0, 128 out_valid pulses with out_idx 0..127 in order, all out_bit=0.
- gate5=(x0,x1,x2), gates 0..4 left at 0 -> tt = 128'hE8E8...E8 (16 bytes of E8).
- gate0=(x3,x4,0), gate5=(w0,w0,x6) -> tt = 128'hFF000000FF000000FF000000FF000000.
- gate0=(x0,x1,w3) as a forward ref, gate5=(w0,w0,x0) -> w3 reads 0, tt = 128'h8888...8.
- Mid-scan: pulse cfg_we and start at p=40 -> cfg_err pulses and config is unchanged on readback. Then drive rst_n=0 at p=60 -> busy=0, tt=0, no done pulse.
- MAJ_INV_EN: gate5=(~0,x0,x1) -> tt = 128'hEEEE...E. With cfg_gate=7 on NUM_GATES=6 -> cfg_err pulses.

Source files
------------

// File: rtl/maj_net_scanner.sv
// Time-shared MAJ3 network scanner: evaluates one gate per cycle over all 128 patterns of x0..x6
// and assembles the output truth table. Define MAJ_INV_EN to add per-operand complement flags.
module maj_net_scanner #(
    parameter int NUM_GATES = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_gate,
    input  logic [3:0]   cfg_sel_a,
    input  logic [3:0]   cfg_sel_b,
    input  logic [3:0]   cfg_sel_c,
`ifdef MAJ_INV_EN
    input  logic [2:0]   cfg_inv,
`endif
    output logic         cfg_err,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    output logic [6:0]   out_idx,
    output logic         out_bit,
    output logic [127:0] tt
);
    // state | meaning
    // IDLE  | accepting config, waiting for start
    // EVAL  | evaluating gate g of pattern p
    // DONE  | one cycle: pulse done, drop busy
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t state, state_d;
    logic [6:0] p;
    logic [2:0] g;
    logic [NUM_GATES-1:0] w;
    logic [3:0] sel_a [NUM_GATES];
    logic [3:0] sel_b [NUM_GATES];
    logic [3:0] sel_c [NUM_GATES];
    logic [2:0] inv [NUM_GATES];
    logic [3:0] cur_a, cur_b, cur_c;
    logic [2:0] cur_inv;
    logic op_a, op_b, op_c, res;
    logic last_gate, bad_gate, busy_d, done_d;

    function automatic logic pick(input logic [3:0] sel, input logic [6:0] pat,
                                  input logic [NUM_GATES-1:0] wv);
        logic r;
        r = 1'b0;
        if (sel >= 4'd1 && sel <= 4'd7)
            r = pat[sel[2:0] - 3'd1];
        for (int j = 0; j < NUM_GATES; j++)
            if (sel == 4'(8 + j))
                r = wv[j];
        return r;
    endfunction

    // Forward references need no special case: w is cleared per pattern and w[j>=g] is unwritten yet.
    always_comb begin
        cur_a = 4'd0;
        cur_b = 4'd0;
        cur_c = 4'd0;
        cur_inv = 3'd0;
        for (int j = 0; j < NUM_GATES; j++) begin
            if (g == 3'(j)) begin
                cur_a = sel_a[j];
                cur_b = sel_b[j];
                cur_c = sel_c[j];
                cur_inv = inv[j];
            end
        end
        op_a = pick(cur_a, p, w) ^ cur_inv[0];
        op_b = pick(cur_b, p, w) ^ cur_inv[1];
        op_c = pick(cur_c, p, w) ^ cur_inv[2];
        res = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    end

    assign last_gate = (g == 3'(NUM_GATES - 1));
    assign bad_gate = (int'(cfg_gate) >= NUM_GATES);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_EVAL;
            S_EVAL:  if (last_gate && p == 7'd127) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= 7'd0;
            out_bit   <= 1'b0;
            tt        <= '0;
            w         <= '0;
            p         <= 7'd0;
            g         <= 3'd0;
            for (int j = 0; j < NUM_GATES; j++) begin
                sel_a[j] <= 4'd0;
                sel_b[j] <= 4'd0;
                sel_c[j] <= 4'd0;
                inv[j]   <= 3'd0;
            end
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= 1'b0;
            cfg_err   <= cfg_we && (state != S_IDLE || bad_gate);
            if (cfg_we && state == S_IDLE && !bad_gate) begin
                for (int j = 0; j < NUM_GATES; j++) begin
                    if (cfg_gate == 3'(j)) begin
                        sel_a[j] <= cfg_sel_a;
                        sel_b[j] <= cfg_sel_b;
                        sel_c[j] <= cfg_sel_c;
`ifdef MAJ_INV_EN
                        inv[j]   <= cfg_inv;
`else
                        inv[j]   <= 3'd0;
`endif
                    end
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p  <= 7'd0;
                        g  <= 3'd0;
                        w  <= '0;
                        tt <= '0;
                    end
                end
                S_EVAL: begin
                    if (last_gate) begin
                        tt[p]     <= res;
                        out_valid <= 1'b1;
                        out_idx   <= p;
                        out_bit   <= res;
                        w         <= '0;
                        g         <= 3'd0;
                        p         <= p + 7'd1;
                    end else begin
                        for (int j = 0; j < NUM_GATES; j++)
                            if (g == 3'(j)) w[j] <= res;
                        g <= g + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
